sram_lsu: RTL and testbench

- Initiator-side load/store unit that drives the team's 64 KiB byte-addressable SRAM port (4-bit byte write-enable, 16-bit byte address, 32-bit write/read data, combinational read).
- Accepts one load/store request at a time from the core over a valid/ready handshake and generates the SRAM byte-enable mask and address.
- For loads, samples the SRAM read data, then sign- or zero-extends it.
- Returns the result on a registered valid/ready response channel.
- Sits between the core's memory stage and the SRAM instance.

---
 rtl/sram_pkg.sv | 35 +++
 rtl/sram_load_ext.sv | 22 ++
 rtl/sram_lsu.sv | 98 +++++++++
 tb/tb_sram_lsu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared encodings for the SRAM load/store unit: size codes, FSM states and
// the byte-enable masks driven onto the SRAM write-enable port.
package sram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Illegal size maps to an empty mask so no SRAM write can occur.
    function automatic logic [3:0] byte_mask(input logic [1:0] size);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = MASK_BYTE;
            SZ_HALF: m = MASK_HALF;
            SZ_WORD: m = MASK_WORD;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_load_ext.sv
// Combinational load extender: picks the low byte/half/word of the SRAM read
// data and sign- or zero-extends it to 32 bits.
module sram_load_ext
    import sram_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] data,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (size)
            SZ_BYTE: result = {{24{~zero_ext & data[7]}}, data[7:0]};
            SZ_HALF: result = {{16{~zero_ext & data[15]}}, data[15:0]};
            SZ_WORD: result = data;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/sram_lsu.sv
// Single-outstanding load/store unit in front of the byte-addressable SRAM.
// Request is captured, issued to the SRAM for one cycle, then held as a response.
module sram_lsu
    import sram_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [3:0]        mem_w_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_e            state;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        w_en_q;
    logic [DATA_W-1:0] ext_data;
    logic              accept;

    // In RESP a new request can only enter on the same edge the response leaves.
    assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
    assign accept    = req_valid && req_ready;

    sram_load_ext u_ext (
        .size     (size_q),
        .zero_ext (uns_q),
        .data     (mem_read_data),
        .result   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            w_en_q     <= 4'b0000;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            // Write enable is only ever live for the single ISSUE cycle.
            w_en_q <= 4'b0000;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                w_en_q  <= req_we ? byte_mask(req_size) : 4'b0000;
            end
            case (state)
                IDLE: begin
                    if (accept) state <= ISSUE;
                end
                ISSUE: begin
                    resp_valid <= 1'b1;
                    resp_err   <= (size_q == SZ_ILL);
                    resp_rdata <= (!we_q && size_q != SZ_ILL) ? ext_data : '0;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= req_valid ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gate with reset so a store interrupted in ISSUE never reaches the array.
    assign mem_w_en       = rst ? 4'b0000 : w_en_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_sram_lsu.sv
// Bench for sram_lsu: behavioural 64 KiB SRAM, expected responses queued at
// request time and compared when the unit hands a response over.
module tb_sram_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  mem_w_en;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t resp_q[$];
    int   checks = 0;
    int   errs   = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    sram_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_w_en       (mem_w_en),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // SRAM model with 16-bit wrapping byte lanes
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_w_en[i]) mem[mem_address + 16'(i)] <= mem_write_data[8*i +: 8];
    end
    assign mem_read_data = {mem[mem_address + 16'd3], mem[mem_address + 16'd2],
                            mem[mem_address + 16'd1], mem[mem_address]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: sampled mid-cycle, the handshake completes at the next edge
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (resp_q.size() == 0) begin
                chk("spurious_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = resp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [15:0] a, input logic [31:0] wd,
                        input logic [3:0] exp_wen, input logic [31:0] exp_rd,
                        input logic exp_err);
        int n;
        exp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        resp_q.push_back(e);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("issue_w_en", 32'(mem_w_en), 32'(exp_wen));
        chk("issue_addr", 32'(mem_address), 32'(a));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (resp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", resp_q.size(), 32'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_w_en", 32'(mem_w_en), 32'd0);
        chk("rst_address", 32'(mem_address), 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: word store/load with latency check
        send(1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        chk("t1_resp_not_yet", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("t1_resp_valid", 32'(resp_valid), 32'd1);
        chk("t1_w_en_off", 32'(mem_w_en), 32'd0);
        drain();
        send(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
        drain();

        // 2: byte and half stores with upper garbage, signed/unsigned loads
        send(1'b1, 2'd0, 1'b0, 16'h0021, 32'hA5A5A580, 4'b0001, 32'h0, 1'b0);
        send(1'b0, 2'd0, 1'b0, 16'h0021, 32'h0, 4'b0000, 32'hFFFFFF80, 1'b0);
        send(1'b0, 2'd0, 1'b1, 16'h0021, 32'h0, 4'b0000, 32'h00000080, 1'b0);
        send(1'b0, 2'd2, 1'b0, 16'h0020, 32'h0, 4'b0000, 32'h00008000, 1'b0);
        send(1'b1, 2'd1, 1'b0, 16'h0030, 32'h77778001, 4'b0011, 32'h0, 1'b0);
        send(1'b0, 2'd1, 1'b0, 16'h0030, 32'h0, 4'b0000, 32'hFFFF8001, 1'b0);
        send(1'b0, 2'd1, 1'b1, 16'h0030, 32'h0, 4'b0000, 32'h00008001, 1'b0);
        drain();

        // 3: address wrap
        send(1'b1, 2'd2, 1'b0, 16'hFFFF, 32'h11223344, 4'b1111, 32'h0, 1'b0);
        send(1'b0, 2'd2, 1'b0, 16'hFFFF, 32'h0, 4'b0000, 32'h11223344, 1'b0);
        drain();
        chk("t3_byte_ffff", 32'(mem[16'hFFFF]), 32'h44);
        chk("t3_byte_0000", 32'(mem[16'h0000]), 32'h33);
        chk("t3_byte_0002", 32'(mem[16'h0002]), 32'h11);

        // 4: illegal size store leaves memory untouched
        send(1'b1, 2'd2, 1'b0, 16'h0040, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
        send(1'b1, 2'd3, 1'b0, 16'h0040, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b1);
        send(1'b0, 2'd2, 1'b0, 16'h0040, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
        drain();

        // 5: backpressure then back-to-back acceptance
        resp_ready = 1'b0;
        send(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        fork
            send(1'b0, 2'd0, 1'b1, 16'h0021, 32'h0, 4'b0000, 32'h00000080, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("t5_req_ready_low", 32'(req_ready), 32'd0);
                    chk("t5_resp_held", 32'(resp_valid), 32'd1);
                    chk("t5_rdata_held", resp_rdata, 32'hDEADBEEF);
                end
                @(posedge clk); #1 resp_ready = 1'b1;
                @(negedge clk);
                chk("t5_req_ready_high", 32'(req_ready), 32'd1);
                @(posedge clk); #1;
                chk("t5_b2b_addr", 32'(mem_address), 32'h0021);
                chk("t5_b2b_issue", 32'(resp_valid), 32'd0);
            end
        join
        drain();

        // 6: reset during the ISSUE cycle of a store
        send(1'b1, 2'd2, 1'b0, 16'h0050, 32'h12345678, 4'b1111, 32'h0, 1'b0);
        drain();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 16'h0050; req_wdata = 32'hAAAAAAAA;
        @(negedge clk);
        chk("t6_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1 chk("t6_w_en_gated", 32'(mem_w_en), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("t6_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(1'b0, 2'd2, 1'b0, 16'h0050, 32'h0, 4'b0000, 32'h12345678, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
